// File: rtl/bsa_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bsa_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit combinational full adder cell used by the bit-serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full_adder, carry kept in a flop.
// Optional SERIAL_SUB_EN adds an in_sub port selecting a - b (two's complement) instead of a + b.
module bit_serial_adder
    import bsa_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef SERIAL_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] load_b;
    logic             load_carry;

`ifdef SERIAL_SUB_EN
    // Subtract as a + ~b + 1; carry-out then means "no borrow".
    assign load_b     = in_sub ? ~in_b : in_b;
    assign load_carry = in_sub | in_cin;
`else
    assign load_b     = in_b;
    assign load_carry = in_cin;
`endif

    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = load_b;
                    carry_d = load_carry;
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                s_d     = {fa_sum, s_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (count_q == LastBit) begin
                    count_d = '0;
                    state_d = StDone;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_sum   = s_q;
    assign out_cout  = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) with a result scoreboard queue.
module tb_bit_serial_adder;

    localparam int unsigned W = 8;
    localparam int unsigned NRand = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef SERIAL_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks = 0;
    int failures = 0;
    logic [W:0] sb[$];

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SERIAL_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // Reference: {cout, sum}; subtraction cout is "a >= b".
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W-1:0] d;
        if (sub) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Present an operand pair and hold it until accepted; returns 1 ps after the accepting edge.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input bit push, output bit ok);
        int n = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_cin = cin;
`ifdef SERIAL_SUB_EN
        in_sub = sub;
`endif
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (in_ready === 1'b1);
        if (ok) begin
            if (push) sb.push_back(model(a, b, cin, sub));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (bounded), capture the result, then handshake it away.
    task automatic drain(output bit ok, output logic [W:0] got);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (out_valid === 1'b1);
        got = {out_cout, out_sum};
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if ({out_cout, out_sum} !== 9'h000) begin
            failures++;
            $display("FAIL reset_result got=%h exp=000", {out_cout, out_sum});
        end
    endtask

    task automatic test_add();
        logic [W-1:0] va[3] = '{8'h3C, 8'hFF, 8'hFF};
        logic [W-1:0] vb[3] = '{8'h42, 8'h01, 8'h00};
        logic         vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [W:0]   vexp[3] = '{9'h07E, 9'h100, 9'h100};
        for (int i = 0; i < 3; i++) begin
            bit ok;
            bit seen = 0;
            int edges = 1;  // the accepting edge counts as edge 1
            logic [W:0] got, exp;
            send_op(va[i], vb[i], vc[i], 1'b0, 1'b1, ok);
            while (!seen && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
                seen = (out_valid === 1'b1);
            end
            checks++;
            if (!ok || edges != W + 1) begin
                failures++;
                $display("FAIL add_latency[%0d] got=%0d edges exp=%0d accepted=%b", i, edges, W + 1, ok);
            end
            exp = sb.pop_front();
            drain(ok, got);
            checks++;
            if (!ok || got !== exp || got !== vexp[i]) begin
                failures++;
                $display("FAIL add_result[%0d] got=%h exp=%h", i, got, vexp[i]);
            end
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL add_release[%0d] got valid=%b ready=%b exp valid=0 ready=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit leak = 0;
        int n = 0;
        logic [W:0] held, got, exp;
        send_op(8'h81, 8'h7F, 1'b1, 1'b0, 1'b1, ok);
        in_valid = 1'b1;
        in_a = 8'hAA;
        in_b = 8'h55;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            if (in_ready !== 1'b0) leak = 1;
            n++;
        end
        checks++;
        if (!ok || leak || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_run_ready got leak=%b valid=%b exp leak=0 valid=1", leak, out_valid);
        end
        held = {out_cout, out_sum};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || {out_cout, out_sum} !== held || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got valid=%b res=%h ready=%b exp valid=1 res=%h ready=0",
                         c, out_valid, {out_cout, out_sum}, in_ready, held);
            end
        end
        exp = sb.pop_front();
        drain(ok, got);
        in_valid = 1'b0;
        checks++;
        if (!ok || got !== exp || got !== 9'h101) begin
            failures++;
            $display("FAIL bp_result got=%h exp=101", got);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_accept got busy=%b ready=%b exp busy=0 ready=1", busy, in_ready);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit spurious = 0;
        logic [W:0] got, exp;
        send_op(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, ok);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (!ok || in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got ready=%b valid=%b sum=%h busy=%b exp 1 0 00 0",
                     in_ready, out_valid, out_sum, busy);
        end
        for (int c = 0; c < W + 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            failures++;
            $display("FAIL abort_no_output got spurious=1 exp 0");
        end
        send_op(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1, ok);
        exp = sb.pop_front();
        drain(ok, got);
        checks++;
        if (!ok || got !== exp) begin
            failures++;
            $display("FAIL abort_recover got=%h exp=%h", got, exp);
        end
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        logic [W-1:0] va[2] = '{8'h10, 8'h01};
        logic [W-1:0] vb[2] = '{8'h01, 8'h02};
        logic [W:0]   vexp[2] = '{9'h10F, 9'h0FF};
        for (int i = 0; i < 2; i++) begin
            bit ok;
            logic [W:0] got;
            send_op(va[i], vb[i], 1'b0, 1'b1, 1'b1, ok);
            void'(sb.pop_front());
            drain(ok, got);
            checks++;
            if (!ok || got !== vexp[i]) begin
                failures++;
                $display("FAIL sub_result[%0d] got=%h exp=%h", i, got, vexp[i]);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < NRand; i++) begin
                    bit ok;
                    logic s;
`ifdef SERIAL_SUB_EN
                    s = 1'($urandom_range(0, 1));
`else
                    s = 1'b0;
`endif
                    send_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), s, 1'b1, ok);
                    if (!ok) begin
                        checks++;
                        failures++;
                        $display("FAIL b2b_accept[%0d] got in_ready=0 exp 1", i);
                        break;
                    end
                end
            end
            begin
                int got_n = 0;
                int cyc = 0;
                while (got_n < NRand && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid === 1'b1 && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL b2b_unexpected got=%h exp none", {out_cout, out_sum});
                        end else begin
                            logic [W:0] exp;
                            exp = sb.pop_front();
                            if ({out_cout, out_sum} !== exp) begin
                                failures++;
                                $display("FAIL b2b_result[%0d] got=%h exp=%h",
                                         got_n, {out_cout, out_sum}, exp);
                            end
                        end
                        got_n++;
                    end
                end
                checks++;
                if (got_n != NRand) begin
                    failures++;
                    $display("FAIL b2b_count got=%0d exp=%0d", got_n, NRand);
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_empty got=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
`ifdef SERIAL_SUB_EN
        in_sub = 1'b0;
`endif
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_abort();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
